// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / load-use hazard unit.
//   FW_SEL_*  : operand select encodings (0 = register file, k = stage k result)
//   ENT_*_W   : tracker entry field widths; entry_w() gives total packed width
//   clog2()   : ceiling log2 for select-width derivation
package fwd_pkg;

  localparam int unsigned FW_SEL_RF  = 0;
  localparam int unsigned FW_SEL_M   = 1;
  localparam int unsigned FW_SEL_W   = 2;
  localparam int unsigned FW_SEL_WB2 = 3;

  localparam int unsigned ENT_WEN_W = 1;
  localparam int unsigned ENT_LD_W  = 1;

  // Packed tracker entry layout is {idx, wen, ld}.
  function automatic int unsigned entry_w(input int unsigned aw);
    return aw + ENT_WEN_W + ENT_LD_W;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_stage_tracker.sv
// Shift pipeline of in-flight producers behind E.
//   i_clk, i_rst_n       : clock, async active-low reset (all entries invalid)
//   i_idx, i_wen, i_ld   : entry captured from E each cycle
//   o_idx/o_wen/o_ld     : flattened entries, bit group k-1 holds stage k
module fwd_stage_tracker
  import fwd_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned REG_AW     = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [REG_AW-1:0]            i_idx,
  input  logic                         i_wen,
  input  logic                         i_ld,
  output logic [FWD_STAGES*REG_AW-1:0] o_idx,
  output logic [FWD_STAGES-1:0]        o_wen,
  output logic [FWD_STAGES-1:0]        o_ld
);

  localparam int unsigned ENT_W = entry_w(REG_AW);

  logic [ENT_W-1:0] r_ent [FWD_STAGES];

  // Always advances; a stall shows up here as a bubble entering from E.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(FWD_STAGES); k++) r_ent[k] <= '0;
    end else begin
      r_ent[0] <= {i_idx, i_wen, i_ld};
      for (int k = 1; k < int'(FWD_STAGES); k++) r_ent[k] <= r_ent[k-1];
    end
  end

  for (genvar k = 0; k < int'(FWD_STAGES); k++) begin : g_unpack
    assign o_idx[k*REG_AW +: REG_AW] = r_ent[k][ENT_W-1 -: REG_AW];
    assign o_wen[k]                  = r_ent[k][1];
    assign o_ld[k]                   = r_ent[k][0];
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall generation for the RV32 filter core.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_rs_idx_d, i_rs_used_d : decode-stage source indices / read enables
//   i_rs_idx_e              : execute-stage source indices
//   i_valid_e, i_rd_idx_e, i_w_en_e, i_is_load_e, i_flush : E-stage producer info
//   o_fw_sel                : per-operand select (0 = RF, k = stage k)
//   o_stall_d               : hold F/D, bubble into E
//   o_stall_cnt             : saturating count of stall cycles
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int unsigned NUM_SRC    = 2,
  parameter  int unsigned FWD_STAGES = 2,
  parameter  int unsigned REG_AW     = 5,
  parameter  int unsigned LOAD_LAT   = 1,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned SEL_W      = clog2(FWD_STAGES + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] i_rs_idx_d,
  input  logic [NUM_SRC-1:0]        i_rs_used_d,
  input  logic [NUM_SRC*REG_AW-1:0] i_rs_idx_e,
  input  logic                      i_valid_e,
  input  logic [REG_AW-1:0]         i_rd_idx_e,
  input  logic                      i_w_en_e,
  input  logic                      i_is_load_e,
  input  logic                      i_flush,
  output logic [NUM_SRC*SEL_W-1:0]  o_fw_sel,
  output logic                      o_stall_d,
  output logic [CNT_W-1:0]          o_stall_cnt
);

  logic                         w_e_wen;
  logic                         w_e_ld_hz;
  logic [FWD_STAGES*REG_AW-1:0] w_trk_idx;
  logic [FWD_STAGES-1:0]        w_trk_wen;
  logic [FWD_STAGES-1:0]        w_trk_ld;
  logic [CNT_W-1:0]             r_stall_cnt;

  // x0 writes and flushed/bubble instructions never become producers.
  assign w_e_wen   = i_valid_e & i_w_en_e & ~i_flush & (i_rd_idx_e != '0);
  assign w_e_ld_hz = i_valid_e & i_w_en_e & i_is_load_e & ~i_flush;

  fwd_stage_tracker #(
    .FWD_STAGES (FWD_STAGES),
    .REG_AW     (REG_AW)
  ) u_tracker (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_idx   (i_rd_idx_e),
    .i_wen   (w_e_wen),
    .i_ld    (i_is_load_e),
    .o_idx   (w_trk_idx),
    .o_wen   (w_trk_wen),
    .o_ld    (w_trk_ld)
  );

  // Youngest-match priority encoder; a too-young load match falls back to RF.
  always_comb begin
    logic [REG_AW-1:0] w_rs;
    logic [SEL_W-1:0]  w_sel;
    logic              w_guard;
    o_fw_sel = '0;
    for (int n = 0; n < int'(NUM_SRC); n++) begin
      w_rs    = i_rs_idx_e[n*REG_AW +: REG_AW];
      w_sel   = SEL_W'(FW_SEL_RF);
      w_guard = 1'b0;
      for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
        if (w_trk_wen[k] && (w_trk_idx[k*REG_AW +: REG_AW] == w_rs)) begin
          w_sel   = SEL_W'(k + 1);
          w_guard = w_trk_ld[k] && (unsigned'(k) < LOAD_LAT);
        end
      end
      if (w_guard || (w_rs == '0)) w_sel = SEL_W'(FW_SEL_RF);
      o_fw_sel[n*SEL_W +: SEL_W] = w_sel;
    end
  end

  // Load-use: load in E, or a load still within its latency window behind E.
  always_comb begin
    logic [REG_AW-1:0] w_rs;
    o_stall_d = 1'b0;
    for (int n = 0; n < int'(NUM_SRC); n++) begin
      w_rs = i_rs_idx_d[n*REG_AW +: REG_AW];
      if (i_rs_used_d[n] && (w_rs != '0)) begin
        if (w_e_ld_hz && (i_rd_idx_e == w_rs)) o_stall_d = 1'b1;
        for (int j = 0; j < int'(LOAD_LAT) - 1; j++) begin
          if (w_trk_wen[j] && w_trk_ld[j] && (w_trk_idx[j*REG_AW +: REG_AW] == w_rs))
            o_stall_d = 1'b1;
        end
      end
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (o_stall_d && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit. Three configurations share one
// stimulus stream: A = defaults, B = 3 stages / load latency 2, C = 4-bit counter.
// An instruction-history model predicts selects, stalls and counts every cycle;
// literal checks pin the model at the interesting points.
module tb_fwd_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS*AW-1:0] rs_idx_d = '0;
  logic [NS*AW-1:0] rs_idx_e = '0;
  logic [NS-1:0] rs_used_d = '0;
  logic          valid_e = 1'b0;
  logic [AW-1:0] rd_idx_e = '0;
  logic          w_en_e = 1'b0;
  logic          is_load_e = 1'b0;
  logic          flush = 1'b0;

  logic [3:0]  sel_a, sel_b, sel_c;
  logic        stall_a, stall_b, stall_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_SRC(NS), .FWD_STAGES(2), .REG_AW(AW), .LOAD_LAT(1), .CNT_W(16)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rs_idx_d(rs_idx_d), .i_rs_used_d(rs_used_d),
    .i_rs_idx_e(rs_idx_e), .i_valid_e(valid_e), .i_rd_idx_e(rd_idx_e), .i_w_en_e(w_en_e),
    .i_is_load_e(is_load_e), .i_flush(flush), .o_fw_sel(sel_a), .o_stall_d(stall_a),
    .o_stall_cnt(cnt_a));

  fwd_hazard_unit #(.NUM_SRC(NS), .FWD_STAGES(3), .REG_AW(AW), .LOAD_LAT(2), .CNT_W(16)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rs_idx_d(rs_idx_d), .i_rs_used_d(rs_used_d),
    .i_rs_idx_e(rs_idx_e), .i_valid_e(valid_e), .i_rd_idx_e(rd_idx_e), .i_w_en_e(w_en_e),
    .i_is_load_e(is_load_e), .i_flush(flush), .o_fw_sel(sel_b), .o_stall_d(stall_b),
    .o_stall_cnt(cnt_b));

  fwd_hazard_unit #(.NUM_SRC(NS), .FWD_STAGES(2), .REG_AW(AW), .LOAD_LAT(1), .CNT_W(4)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_rs_idx_d(rs_idx_d), .i_rs_used_d(rs_used_d),
    .i_rs_idx_e(rs_idx_e), .i_valid_e(valid_e), .i_rd_idx_e(rd_idx_e), .i_w_en_e(w_en_e),
    .i_is_load_e(is_load_e), .i_flush(flush), .o_fw_sel(sel_c), .o_stall_d(stall_c),
    .o_stall_cnt(cnt_c));

  // History of what left E: h_*[k] describes the instruction that was in E k cycles ago.
  logic [AW-1:0] h_rd [1:3];
  logic          h_wr [1:3];
  logic          h_ld [1:3];
  int            m_cnt_a = 0, m_cnt_b = 0, m_cnt_c = 0;
  int            n_asrt = 0, n_fail = 0;
  bit            chk_en = 1'b0;

  function automatic int m_sel(int stages, int lat, logic [AW-1:0] rs);
    if (rs == 0) return 0;
    for (int k = 1; k <= stages; k++)
      if (h_wr[k] && h_rd[k] == rs) return (h_ld[k] && k <= lat) ? 0 : k;
    return 0;
  endfunction

  function automatic int m_stall(int lat);
    logic [AW-1:0] rs;
    for (int n = 0; n < int'(NS); n++) begin
      rs = rs_idx_d[n*AW +: AW];
      if (rs_used_d[n] && rs != 0) begin
        if (valid_e && w_en_e && is_load_e && !flush && rd_idx_e == rs) return 1;
        for (int a = 1; a < lat; a++)
          if (h_wr[a] && h_ld[a] && h_rd[a] == rs) return 1;
      end
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= 3; k++) begin
        h_rd[k] <= '0; h_wr[k] <= 1'b0; h_ld[k] <= 1'b0;
      end
      m_cnt_a <= 0; m_cnt_b <= 0; m_cnt_c <= 0;
    end else begin
      if (m_stall(1) != 0) begin
        if (m_cnt_a < 65535) m_cnt_a <= m_cnt_a + 1;
        if (m_cnt_c < 15)    m_cnt_c <= m_cnt_c + 1;
      end
      if (m_stall(2) != 0 && m_cnt_b < 65535) m_cnt_b <= m_cnt_b + 1;
      for (int k = 3; k > 1; k--) begin
        h_rd[k] <= h_rd[k-1]; h_wr[k] <= h_wr[k-1]; h_ld[k] <= h_ld[k-1];
      end
      h_rd[1] <= rd_idx_e;
      h_wr[1] <= valid_e && w_en_e && !flush && (rd_idx_e != 0);
      h_ld[1] <= is_load_e;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < int'(NS); n++) begin
        cmp($sformatf("model_sel_a%0d", n), 32'(sel_a[n*2 +: 2]), m_sel(2, 1, rs_idx_e[n*AW +: AW]));
        cmp($sformatf("model_sel_b%0d", n), 32'(sel_b[n*2 +: 2]), m_sel(3, 2, rs_idx_e[n*AW +: AW]));
        cmp($sformatf("model_sel_c%0d", n), 32'(sel_c[n*2 +: 2]), m_sel(2, 1, rs_idx_e[n*AW +: AW]));
      end
      cmp("model_stall_a", 32'(stall_a), m_stall(1));
      cmp("model_stall_b", 32'(stall_b), m_stall(2));
      cmp("model_stall_c", 32'(stall_c), m_stall(1));
      cmp("model_cnt_a", 32'(cnt_a), m_cnt_a);
      cmp("model_cnt_b", 32'(cnt_b), m_cnt_b);
      cmp("model_cnt_c", 32'(cnt_c), m_cnt_c);
    end
  end

  task automatic drive(input bit v, input logic [AW-1:0] rd, input bit we, input bit ld,
                       input bit fl, input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                       input logic [AW-1:0] d0, input logic [AW-1:0] d1, input logic [1:0] used);
    @(posedge clk);
    #1;
    valid_e = v; rd_idx_e = rd; w_en_e = we; is_load_e = ld; flush = fl;
    rs_idx_e = {e1, e0}; rs_idx_d = {d1, d0}; rs_used_d = used;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    @(negedge clk);
    cmp("reset_sel_a", 32'(sel_a), 0);
    cmp("reset_cnt_a", 32'(cnt_a), 0);
    cmp("reset_stall_a", 32'(stall_a), 0);
    chk_en = 1'b1;
    #2 rst_n = 1'b1;

    // Forward from M.
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    drive(1, 6, 1, 0, 0, 5, 0, 0, 0, 2'b00);
    @(negedge clk); cmp("fwd_m", 32'(sel_a[1:0]), 1);

    // Back-to-back x7 writers: youngest wins, then W.
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 7, 7, 0, 0, 2'b00);
    @(negedge clk); cmp("youngest_op0", 32'(sel_a[1:0]), 1); cmp("youngest_op1", 32'(sel_a[3:2]), 1);
    drive(0, 0, 0, 0, 0, 7, 7, 0, 0, 2'b00);
    @(negedge clk); cmp("fwd_w_op1", 32'(sel_a[3:2]), 2);

    // x0 is neither a hazard nor a forwarding source.
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01);
    @(negedge clk); cmp("x0_no_stall", 32'(stall_a), 0);
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    @(negedge clk); cmp("x0_no_fwd", 32'(sel_a), 0);

    // Load-use, latency 1 (A) and latency 2 (B).
    drive(1, 3, 1, 1, 0, 0, 0, 3, 0, 2'b01);
    @(negedge clk); cmp("lu1_stall_a", 32'(stall_a), 1); cmp("lu1_stall_b", 32'(stall_b), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 3, 0, 2'b01);
    @(negedge clk); cmp("lu1_release_a", 32'(stall_a), 0); cmp("lu1_hold_b", 32'(stall_b), 1);
    drive(1, 10, 1, 0, 0, 3, 0, 0, 0, 2'b00);
    @(negedge clk);
    cmp("lu1_sel_a", 32'(sel_a[1:0]), 2); cmp("lu1_cnt_a", 32'(cnt_a), 1);
    cmp("lu1_guard_b", 32'(sel_b[1:0]), 0); cmp("lu1_cnt_b", 32'(cnt_b), 2);

    drive(1, 3, 1, 1, 0, 0, 0, 3, 0, 2'b01);
    @(negedge clk); cmp("lu2_stall1_b", 32'(stall_b), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 3, 0, 2'b01);
    @(negedge clk); cmp("lu2_stall2_b", 32'(stall_b), 1); cmp("lu2_nostall_a", 32'(stall_a), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 3, 0, 2'b01);
    @(negedge clk); cmp("lu2_release_b", 32'(stall_b), 0);
    drive(1, 11, 1, 0, 0, 3, 0, 0, 0, 2'b00);
    @(negedge clk);
    cmp("lu2_sel_b", 32'(sel_b[1:0]), 3); cmp("lu2_sel_a", 32'(sel_a[1:0]), 0);
    cmp("lu2_cnt_b", 32'(cnt_b), 4); cmp("lu2_cnt_a", 32'(cnt_a), 2);

    // Flushed load is never a producer.
    drive(1, 4, 1, 1, 1, 0, 0, 0, 4, 2'b10);
    @(negedge clk); cmp("flush_stall_a", 32'(stall_a), 0); cmp("flush_stall_b", 32'(stall_b), 0);
    drive(0, 0, 0, 0, 0, 4, 4, 0, 0, 2'b00);
    @(negedge clk); cmp("flush_sel_a", 32'(sel_a), 0); cmp("flush_sel_b", 32'(sel_b), 0);
    drive(0, 0, 0, 0, 0, 4, 4, 0, 0, 2'b00);
    @(negedge clk); cmp("flush_sel_b_late", 32'(sel_b), 0);

    // Held stall: C saturates at 15, A keeps counting.
    repeat (20) drive(1, 9, 1, 1, 0, 0, 0, 0, 9, 2'b10);
    @(negedge clk);
    cmp("sat_cnt_c", 32'(cnt_c), 15); cmp("sat_cnt_a", 32'(cnt_a), 21); cmp("sat_stall_c", 32'(stall_c), 1);
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    @(negedge clk); cmp("sat_hold_c", 32'(cnt_c), 15); cmp("sat_cnt_a2", 32'(cnt_a), 22);
    drive(0, 0, 0, 0, 0, 9, 0, 0, 0, 2'b00);
    @(negedge clk); cmp("pre_rst_sel_a", 32'(sel_a[1:0]), 1);

    // Mid-cycle asynchronous reset.
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_sel_a", 32'(sel_a), 0); cmp("arst_sel_b", 32'(sel_b), 0);
    cmp("arst_cnt_a", 32'(cnt_a), 0); cmp("arst_cnt_b", 32'(cnt_b), 0); cmp("arst_cnt_c", 32'(cnt_c), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 12, 0, 0, 0, 2'b00);
    @(negedge clk); cmp("post_rst_fwd", 32'(sel_a[1:0]), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
